// File: rtl/rx_chan_sched.sv
// rtl/rx_chan_sched.sv - RX channel scheduler: snapshots I/Q sample sets and serializes them into the RX FIFO
// Handshaked sequencer with stall on fifo_full, sticky overrun on dropped sets and a burst counter.
module rx_chan_sched #(
    parameter int NCH_MAX = 4,
    parameter int DW      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    strobe,
    input  logic [2:0]              num_chan,
    input  logic [NCH_MAX*2*DW-1:0] ch_data,
    input  logic                    fifo_full,
    output logic                    fifo_wrreq,
    output logic [DW-1:0]           fifo_data,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clear_status,
    output logic [15:0]             sets_sent
);

    localparam int NW = 2 * NCH_MAX;
    localparam int IW = $clog2(NW);
    localparam logic [2:0] LAST_MAX = 3'(NCH_MAX - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    logic [DW-1:0] snap [NW];
    logic [IW-1:0] idx;
    logic [IW-1:0] last_idx;
    logic [2:0]    last_ch;
    logic [3:0]    last_w;
    logic          take;
    logic          drop;

    always_comb begin
        last_ch = (num_chan > LAST_MAX) ? LAST_MAX : num_chan;
        last_w  = {last_ch, 1'b1};
        take    = (state == IDLE) && strobe && enable && !fifo_full;
        // A set arriving mid-burst, or while the FIFO is full at accept time, is lost.
        drop    = strobe && enable && ((state == SEND) || fifo_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            last_idx   <= '0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            sets_sent  <= '0;
        end else begin
            fifo_wrreq <= 1'b0;
            if (drop)
                overrun <= 1'b1;
            else if (clear_status)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (take) begin
                        for (int k = 0; k < NW; k++)
                            snap[k] <= ch_data[k*DW +: DW];
                        last_idx <= last_w[IW-1:0];
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!fifo_full) begin
                        fifo_wrreq <= 1'b1;
                        fifo_data  <= snap[idx];
                        if (idx == last_idx) begin
                            busy      <= 1'b0;
                            sets_sent <= sets_sent + 16'd1;
                            state     <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_chan_sched.sv
// tb/tb_rx_chan_sched.sv - randomized bench for rx_chan_sched against a queue-based burst model
module tb_rx_chan_sched;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic                reset = 1'b1;
    logic                clk = 1'b0;
    logic                enable = 1'b0;
    logic                strobe = 1'b0;
    logic [2:0]          num_chan = '0;
    logic [NCH*2*DW-1:0] ch_data = '0;
    logic                fifo_full = 1'b0;
    logic                clear_status = 1'b0;
    logic                fifo_wrreq;
    logic [DW-1:0]       fifo_data;
    logic                busy;
    logic                overrun;
    logic [15:0]         sets_sent;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_q[$];
    int            m_sets = 0;
    bit            m_ovr = 1'b0;
    logic [DW-1:0] m_data = '0;
    bit            m_wr = 1'b0;

    rx_chan_sched #(.NCH_MAX(NCH), .DW(DW)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .strobe(strobe),
        .num_chan(num_chan),
        .ch_data(ch_data),
        .fifo_full(fifo_full),
        .fifo_wrreq(fifo_wrreq),
        .fifo_data(fifo_data),
        .busy(busy),
        .overrun(overrun),
        .clear_status(clear_status),
        .sets_sent(sets_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Burst-level reference: a pending burst is a queue of words; an empty queue means idle.
    task automatic model_step();
        bit drop;
        int n;
        drop = 1'b0;
        m_wr = 1'b0;
        if (reset) begin
            m_q.delete();
            m_sets = 0;
            m_ovr  = 1'b0;
            m_data = '0;
        end else begin
            if (m_q.size() != 0) begin
                if (strobe && enable) drop = 1'b1;
                if (!fifo_full) begin
                    m_wr   = 1'b1;
                    m_data = m_q.pop_front();
                    if (m_q.size() == 0) m_sets = (m_sets + 1) % 65536;
                end
            end else if (strobe && enable) begin
                if (fifo_full) begin
                    drop = 1'b1;
                end else begin
                    n = (int'(num_chan) + 1 > NCH) ? NCH : int'(num_chan) + 1;
                    for (int k = 0; k < 2 * n; k++) m_q.push_back(ch_data[k*DW +: DW]);
                end
            end
            if (drop) m_ovr = 1'b1;
            else if (clear_status) m_ovr = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("wrreq", 32'(fifo_wrreq), 32'(m_wr));
        check("data", 32'(fifo_data), 32'(m_data));
        check("busy", 32'(busy), 32'(m_q.size() != 0));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("sets_sent", 32'(sets_sent), 32'(m_sets));
        strobe       = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill_seq();
        for (int k = 0; k < 2 * NCH; k++) ch_data[k*DW +: DW] = 16'(16'h1111 * (k + 1));
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 2 * NCH; k++) ch_data[k*DW +: DW] = 16'($urandom);
    endtask

    initial begin
        idle(2);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wrreq", 32'(fifo_wrreq), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;

        // Two-channel burst, unstalled.
        fill_seq();
        num_chan = 3'd1;
        strobe   = 1'b1;
        idle(7);
        check("burst1_sets", 32'(sets_sent), 32'd1);

        // Same burst with a 3-cycle stall after the second word.
        strobe = 1'b1;
        idle(3);
        fifo_full = 1'b1;
        idle(3);
        fifo_full = 1'b0;
        idle(5);
        check("stall_sets", 32'(sets_sent), 32'd2);

        // Eight-word burst with a second strobe two cycles in.
        num_chan = 3'd3;
        strobe   = 1'b1;
        idle(2);
        strobe = 1'b1;
        idle(10);
        check("drop_ovr", 32'(overrun), 32'd1);
        clear_status = 1'b1;
        idle(2);
        check("clear_ovr", 32'(overrun), 32'd0);

        // Drop on full in idle; then drop and clear together.
        fifo_full = 1'b1;
        strobe    = 1'b1;
        idle(2);
        strobe       = 1'b1;
        clear_status = 1'b1;
        idle(2);
        check("set_wins", 32'(overrun), 32'd1);
        fifo_full    = 1'b0;
        clear_status = 1'b1;
        idle(1);

        // Channel count clamp, then strobe while disabled.
        num_chan = 3'd7;
        fill_rand();
        strobe = 1'b1;
        idle(10);
        enable = 1'b0;
        strobe = 1'b1;
        idle(3);
        check("disabled_ovr", 32'(overrun), 32'd0);
        enable = 1'b1;

        // Reset at the third word, then a fresh burst.
        num_chan = 3'd1;
        fill_seq();
        strobe = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_sets", 32'(sets_sent), 32'd0);
        strobe = 1'b1;
        idle(6);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 9) < 8);
            strobe       = ($urandom_range(0, 5) == 0);
            fifo_full    = ($urandom_range(0, 3) == 0);
            clear_status = ($urandom_range(0, 9) == 0);
            num_chan     = 3'($urandom_range(0, 7));
            fill_rand();
            tick();
        end
        reset     = 1'b0;
        fifo_full = 1'b0;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_chan_sched.md
Name: rx_chan_sched

Overview:
Receive-side channel scheduler that sequences the per-channel I/Q datapath into the single 16-bit RX FIFO write port. On each decimated-sample strobe, while enabled, it snapshots all active channels and serializes them as I0,Q0,I1,Q1,…, with stall on FIFO full and sticky overrun reporting. It sits between the decimators and the RX FIFO and replaces free-running select counters with a handshaked sequencer.

Parameters:
NCH_MAX, 4, number of physical channels supported (1..8)
DW, 16, width of each I or Q sample word

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  accept new sample sets when high
strobe  in  1  one-cycle pulse: decimated sample set valid on ch_data
num_chan  in  3  index of last active channel (0 = one channel); sampled at accept
ch_data  in  NCH_MAX*2*DW  channel k I at [(2k)*DW +: DW], Q at [(2k+1)*DW +: DW]
fifo_full  in  1  RX FIFO cannot accept a write this cycle
fifo_wrreq  out  1  write strobe to RX FIFO
fifo_data  out  DW  word written when fifo_wrreq high
busy  out  1  burst in progress
overrun  out  1  sticky: a sample set was dropped
clear_status  in  1  clears overrun
sets_sent  out  16  count of completed bursts, wraps at 65535→0

Behaviour:
- Reset: fifo_wrreq=0, fifo_data=0, busy=0, overrun=0, sets_sent=0, state=IDLE, word index=0. Reset mid-burst aborts the burst immediately; no partial-burst completion.
- States: IDLE, SEND.
- Accept: in IDLE, strobe&&enable → latch ch_data into snapshot register, latch last=min(num_chan, NCH_MAX-1), word index=0, busy=1, go SEND. If fifo_full is high in the accept cycle, drop the set, set overrun, stay IDLE.
- SEND: each cycle with fifo_full=0 → fifo_wrreq=1, fifo_data=snapshot word[index], index+1. With fifo_full=1 → fifo_wrreq=0, index held (stall), fifo_data holds.
- Word order: index 2k = I of channel k, 2k+1 = Q of channel k. Burst length = 2*(last+1) words.
- Last word written → sets_sent+1, busy=0, go IDLE in the following cycle. No back-to-back accept in the cycle the last word is written; earliest new accept is the next cycle.
- Latency: strobe accepted at cycle N; first fifo_wrreq at N+1; unstalled burst ends at N+2*(last+1).
- strobe&&enable while in SEND → set dropped, overrun=1, current burst unaffected.
- enable deasserted mid-burst → burst completes; only new accepts are gated.
- num_chan and ch_data changes during SEND have no effect (snapshot used).
- overrun: set on any drop, cleared by clear_status; same-cycle set and clear → set wins.
- Outputs registered; fifo_wrreq never asserted in a cycle where fifo_full was high.
- strobe without enable is ignored silently (no overrun).

Test Plan:
- num_chan=1, ch_data I0=0x1111,Q0=0x2222,I1=0x3333,Q1=0x4444, strobe@N, fifo_full=0 → wrreq N+1..N+4 with data 1111,2222,3333,4444; busy low after N+4; sets_sent=1.
- Same burst, fifo_full high for 3 cycles after second word → exactly 4 writes, order preserved, no write during full cycles, burst ends at N+7.
- Second strobe two cycles after first (num_chan=3, 8-word burst) → first burst completes unchanged, overrun=1, sets_sent=1; clear_status with no new drop → overrun=0.
- strobe with fifo_full=1 in IDLE → no writes, overrun=1; simultaneous clear_status and drop → overrun stays 1.
- num_chan=7 with NCH_MAX=4 → burst of 8 words (clamped to channels 0..3); enable=0 with strobe → no activity, overrun=0.
- reset asserted at the third word of a 4-word burst → next cycle wrreq=0, busy=0, sets_sent=0, overrun=0; a new strobe afterwards produces a complete burst starting at I0.
